// File: rtl/alu_result_capture.sv
// Two-entry in-order capture buffer for ALU results and their flags.
// Also owns the architectural condition-code register.
module alu_result_capture #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_fn,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zf,
  output logic             out_sf,
  output logic             out_of,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zf;
    logic             sf;
    logic             of;
  } entry_t;

  entry_t     mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;

  logic   push;
  logic   pop;
  logic   sa;
  logic   sb;
  logic   sr;
  logic   is_add;
  logic   is_sub;
  entry_t fresh;

  // Handshake depends on registered count only.
  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign sa     = in_a[WIDTH-1];
  assign sb     = in_b[WIDTH-1];
  assign sr     = in_result[WIDTH-1];
  assign is_add = (in_fn == 4'd0);
  assign is_sub = (in_fn == 4'd1);

  always_comb begin
    fresh.result = in_result;
    fresh.zf     = (in_result == '0);
    fresh.sf     = sr;
    fresh.of     = 1'b0;
    unique case (1'b1)
      is_add:  fresh.of = (sa == sb) && (sr != sa);
      // sub computes b - a, so overflow is judged against b's sign
      is_sub:  fresh.of = (sa != sb) && (sr != sb);
      default: fresh.of = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      cc_zf  <= 1'b1;
      cc_sf  <= 1'b0;
      cc_of  <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= fresh;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (push && in_set_cc) begin
        cc_zf <= fresh.zf;
        cc_sf <= fresh.sf;
        cc_of <= fresh.of;
      end
    end
  end

  assign out_result = mem[rd_ptr].result;
  assign out_zf     = mem[rd_ptr].zf;
  assign out_sf     = mem[rd_ptr].sf;
  assign out_of     = mem[rd_ptr].of;

endmodule

// File: tb/tb_alu_result_capture.sv
// Randomized bench for alu_result_capture against a queue model.
// Directed scenarios first, then random traffic with sporadic resets.
module tb_alu_result_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_fn;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic [63:0] in_result;
  logic        in_set_cc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic        out_zf;
  logic        out_sf;
  logic        out_of;
  logic        cc_zf;
  logic        cc_sf;
  logic        cc_of;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [63:0] r;
    logic        zf;
    logic        sf;
    logic        of;
  } ent_t;

  ent_t q[$];
  logic m_zf;
  logic m_sf;
  logic m_of;
  logic fresh;

  always #5 clk = ~clk;

  alu_result_capture #(.WIDTH(64)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_fn(in_fn),
    .in_a(in_a),
    .in_b(in_b),
    .in_result(in_result),
    .in_set_cc(in_set_cc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_zf(out_zf),
    .out_sf(out_sf),
    .out_of(out_of),
    .cc_zf(cc_zf),
    .cc_sf(cc_sf),
    .cc_of(cc_of)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ent_t ref_ent(input logic [3:0] fn,
                                   input logic [63:0] a,
                                   input logic [63:0] b,
                                   input logic [63:0] r);
    ent_t e;
    bit an, bn, rn;
    an = $signed(a) < 0;
    bn = $signed(b) < 0;
    rn = $signed(r) < 0;
    e.r  = r;
    e.zf = (r == 64'd0);
    e.sf = rn;
    e.of = 1'b0;
    if (fn == 4'd0) e.of = (an == bn) && (rn != an);
    if (fn == 4'd1) e.of = (an != bn) && (rn != bn);
    return e;
  endfunction

  task automatic check_outputs();
    check("in_ready", in_ready, q.size() < 2);
    check("out_valid", out_valid, q.size() > 0);
    check("cc_zf", cc_zf, m_zf);
    check("cc_sf", cc_sf, m_sf);
    check("cc_of", cc_of, m_of);
    if (q.size() > 0) begin
      check("out_result", out_result, q[0].r);
      check("out_zf", out_zf, q[0].zf);
      check("out_sf", out_sf, q[0].sf);
      check("out_of", out_of, q[0].of);
    end else if (fresh) begin
      check("rst_result", out_result, 64'd0);
      check("rst_flags", {out_zf, out_sf, out_of}, 3'b000);
    end
  endtask

  // Called at a negedge: drive inputs, advance model, check next negedge.
  task automatic step(input logic v, input logic [3:0] fn,
                      input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] r, input logic sc,
                      input logic ordy, input logic rs);
    bit do_push, do_pop;
    ent_t e;
    rst = rs; in_valid = v; in_fn = fn; in_a = a;
    in_b = b; in_result = r; in_set_cc = sc; out_ready = ordy;
    if (rs) begin
      q.delete();
      m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
      fresh = 1'b1;
    end else begin
      do_pop  = (q.size() > 0) && ordy;
      do_push = v && (q.size() < 2);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e = ref_ent(fn, a, b, r);
        q.push_back(e);
        fresh = 1'b0;
        if (sc) begin
          m_zf = e.zf; m_sf = e.sf; m_of = e.of;
        end
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 4'd0, 64'd0, 64'd0, 64'd0, 1'b0, ordy, 1'b0);
  endtask

  task automatic push(input logic [3:0] fn, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] r,
                      input logic sc, input logic ordy);
    step(1'b1, fn, a, b, r, sc, ordy, 1'b0);
  endtask

  initial begin
    logic [3:0]  fn;
    logic [63:0] a, b, r;
    m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0; fresh = 1'b1;
    @(negedge clk);
    step(1'b1, 4'd0, 64'd1, 64'd1, 64'd2, 1'b1, 1'b1, 1'b1);
    step(1'b0, 4'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);

    push(4'd3, 64'd10, 64'd3, 64'd9, 1'b1, 1'b0);
    check("d33_res", out_result, 64'd9);
    check("d33_cc", {cc_zf, cc_sf, cc_of}, 3'b000);
    idle(1'b1);

    push(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
         64'h8000_0000_0000_0000, 1'b1, 1'b0);
    check("d34_flags", {out_zf, out_sf, out_of}, 3'b011);
    idle(1'b1);

    push(4'd1, 64'd5, 64'd5, 64'd0, 1'b0, 1'b0);
    check("d35_zf", out_zf, 1'b1);
    check("d35_cc", {cc_zf, cc_sf, cc_of}, 3'b011);
    idle(1'b1);

    push(4'd2, 64'd1, 64'd1, 64'd1, 1'b0, 1'b0);
    push(4'd2, 64'd2, 64'd2, 64'd2, 1'b0, 1'b0);
    check("d36_full", in_ready, 1'b0);
    push(4'd2, 64'd3, 64'd3, 64'd3, 1'b1, 1'b0);
    check("d36_head1", out_result, 64'd1);
    idle(1'b1);
    check("d36_head2", out_result, 64'd2);
    idle(1'b1);
    check("d36_empty", out_valid, 1'b0);

    push(4'd3, 64'd0, 64'd5, 64'd5, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      push(4'd3, 64'd0, 64'd7 + i, 64'd7 + i, 1'b1, 1'b1);
      check("d37_head", out_result, 64'd7 + i);
    end
    idle(1'b1);

    push(4'd0, 64'd1, 64'd2, 64'd3, 1'b1, 1'b0);
    push(4'd0, 64'd1, 64'd2, 64'd3, 1'b1, 1'b0);
    step(1'b1, 4'd0, 64'd1, 64'd1, 64'd2, 1'b1, 1'b1, 1'b1);
    check("d38_valid", out_valid, 1'b0);
    check("d38_ready", in_ready, 1'b1);
    check("d38_cc", {cc_zf, cc_sf, cc_of}, 3'b100);

    for (int i = 0; i < 3000; i++) begin
      fn = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                       : 4'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        a = 64'($urandom_range(0, 3));
        b = 64'($urandom_range(0, 3));
      end else begin
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
      end
      case (fn)
        4'd0:    r = a + b;
        4'd1:    r = b - a;
        4'd2:    r = a & b;
        4'd3:    r = a ^ b;
        default: r = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 7) == 0) r = {$urandom, $urandom};
      step(1'($urandom_range(0, 1)), fn, a, b, r,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 63) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
